// File: rtl/alu_pkg.sv
// Shared ALU definitions: slice geometry, saturation limits and the
// serial subtractor's FSM state encoding.
package alu_pkg;

  localparam int WIDTH = 16;
  localparam int SLICE = 4;

  localparam logic [15:0] SAT_POS = 16'h7FFF;
  localparam logic [15:0] SAT_NEG = 16'h8000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sub_serial_16bit_if.sv
// Operand/result bus for the serial subtractor.
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high; the source holds valid and its payload stable until that edge.
interface sub_serial_16bit_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             sat;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Result;
  logic             N;
  logic             Z;
  logic             V;

  modport master (
    output in_valid, A, B, sat, out_ready,
    input  in_ready, out_valid, Result, N, Z, V
  );

  modport slave (
    input  in_valid, A, B, sat, out_ready,
    output in_ready, out_valid, Result, N, Z, V
  );
endinterface

// File: rtl/sub_slice_4bit.sv
// One 4-bit ripple slice: Sum/Cout = A + Bn + Cin. Subtraction comes from the
// caller feeding the inverted subtrahend and a carry-in of 1 on slice 0.
module sub_slice_4bit (
  input  logic [3:0] A,
  input  logic [3:0] Bn,
  input  logic       Cin,
  output logic [3:0] Sum,
  output logic       Cout
);

  assign {Cout, Sum} = {1'b0, A} + {1'b0, Bn} + {4'b0000, Cin};

endmodule

// File: rtl/sub_serial_16bit.sv
// Multi-cycle A-B: one 4-bit slice per cycle through a shared slice adder,
// registered borrow chain, N/Z/V flags and optional signed saturation.
module sub_serial_16bit
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH,
  parameter int SLICE = alu_pkg::SLICE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sub_serial_16bit_if.slave    bus,
  output state_t               dbg_state
);

  localparam int NSL   = WIDTH / SLICE;
  localparam int IDX_W = $clog2(NSL);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSL - 1);
  localparam logic [WIDTH-1:0] SAT_P = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_N = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             state_q, state_d;
  logic               accept, step, finish;
  logic [WIDTH-1:0]   a_q, bn_q, res_q;
  logic               sat_q, carry_q;
  logic [IDX_W-1:0]   idx_q;
  logic               n_q, z_q, v_q;

  logic [SLICE-1:0]   a_sl, bn_sl, sum_sl;
  logic               cout_sl;
  logic [WIDTH-1:0]   raw, final_res;
  logic               ovf, a_msb, b_msb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (idx_q == LAST_IDX) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign a_sl  = a_q[int'(idx_q)*SLICE +: SLICE];
  assign bn_sl = bn_q[int'(idx_q)*SLICE +: SLICE];

  sub_slice_4bit u_slice (
    .A    (a_sl),
    .Bn   (bn_sl),
    .Cin  (carry_q),
    .Sum  (sum_sl),
    .Cout (cout_sl)
  );

  // The final slice is merged combinationally so saturation and flags can be
  // registered on the same edge that writes the top slice.
  always_comb begin
    raw = res_q;
    raw[int'(idx_q)*SLICE +: SLICE] = sum_sl;
    a_msb     = a_q[WIDTH-1];
    b_msb     = ~bn_q[WIDTH-1];
    ovf       = (a_msb != b_msb) && (raw[WIDTH-1] != a_msb);
    final_res = (sat_q && ovf) ? (a_msb ? SAT_N : SAT_P) : raw;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      bn_q    <= '0;
      sat_q   <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      res_q   <= '0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      if (accept) begin
        a_q     <= bus.A;
        bn_q    <= ~bus.B;
        sat_q   <= bus.sat;
        carry_q <= 1'b1;
        idx_q   <= '0;
      end
      if (step) begin
        res_q[int'(idx_q)*SLICE +: SLICE] <= sum_sl;
        carry_q <= cout_sl;
        idx_q   <= idx_q + 1'b1;
      end
      if (finish) begin
        res_q <= final_res;
        v_q   <= ovf;
        n_q   <= final_res[WIDTH-1];
        z_q   <= (final_res == '0);
      end
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.Result    = res_q;
  assign bus.N         = n_q;
  assign bus.Z         = z_q;
  assign bus.V         = v_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_sub_serial_16bit.sv
// Self-checking bench for sub_serial_16bit: directed corner cases, reset
// mid-calculation, backpressure and randomized operands against an integer model.
module tb_sub_serial_16bit;
  import alu_pkg::*;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  state_t dbg_state;
  int     checks = 0;
  int     failures = 0;
  logic   prev_hs = 1'b0;
  logic [18:0] exp_q[$];

  sub_serial_16bit_if bus ();

  sub_serial_16bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // {V, Z, N, Result} from signed integer arithmetic
  function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic s);
    int d;
    logic [15:0] r;
    logic v;
    d = int'($signed(a)) - int'($signed(b));
    v = (d > 32767) || (d < -32768);
    r = a - b;
    if (s && v) r = a[15] ? 16'h8000 : 16'h7FFF;
    return {v, (r == 16'h0000), r[15], r};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // scoreboard compare process
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hs = 1'b0;
    end else begin
      if (prev_hs) begin
        check("hs_out_valid_drop", {31'b0, bus.out_valid}, 32'd0);
        check("hs_in_ready_rise", {31'b0, bus.in_ready}, 32'd1);
      end
      prev_hs = 1'b0;
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", {31'b0, bus.out_valid}, 32'd0);
        end else begin
          check("result_vznr", {13'b0, bus.V, bus.Z, bus.N, bus.Result}, {13'b0, exp_q[0]});
        end
        check("busy_in_ready", {31'b0, bus.in_ready}, 32'd0);
        if (bus.out_ready) begin
          prev_hs = 1'b1;
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
      end
    end
  end

  // driver: one full transaction, caller is positioned just after a posedge
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                       input int stall);
    check("idle_in_ready", {31'b0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.A = a;
    bus.B = b;
    bus.sat = s;
    @(posedge clk);
    exp_q.push_back(model(a, b, s));
    #1;
    bus.in_valid = 1'b0;
    bus.A = 16'($urandom);
    bus.B = 16'($urandom);
    bus.sat = 1'($urandom);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check("latency_out_valid", {31'b0, bus.out_valid}, {31'b0, (i == 5)});
      if (i == 3) begin
        bus.A = 16'($urandom);
        bus.B = 16'($urandom);
      end
    end
    @(posedge clk);
    #1;
    repeat (stall) begin
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  function automatic logic [15:0] pick();
    logic [15:0] corners[6];
    corners = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h8001};
    if ($urandom_range(0, 2) == 0) return corners[$urandom_range(0, 5)];
    return 16'($urandom);
  endfunction

  initial begin
    bus.in_valid = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.sat = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("reset_result_flags", {13'b0, bus.V, bus.Z, bus.N, bus.Result}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // pin the model to hand-computed values
    check("model_5_3", {13'b0, model(16'h0005, 16'h0003, 1'b0)}, {13'b0, 3'b000, 16'h0002});
    check("model_eq", {13'b0, model(16'h1234, 16'h1234, 1'b0)}, {13'b0, 3'b010, 16'h0000});
    check("model_sat_neg", {13'b0, model(16'h8000, 16'h0001, 1'b1)}, {13'b0, 3'b101, 16'h8000});
    check("model_wrap", {13'b0, model(16'h8000, 16'h0001, 1'b0)}, {13'b0, 3'b100, 16'h7FFF});
    check("model_sat_pos", {13'b0, model(16'h7FFF, 16'hFFFF, 1'b1)}, {13'b0, 3'b100, 16'h7FFF});
    check("model_neg1", {13'b0, model(16'h0000, 16'h0001, 1'b0)}, {13'b0, 3'b001, 16'hFFFF});

    do_op(16'h0005, 16'h0003, 1'b0, 0);
    do_op(16'h1234, 16'h1234, 1'b0, 1);
    do_op(16'h8000, 16'h0001, 1'b1, 0);
    do_op(16'h8000, 16'h0001, 1'b0, 2);
    do_op(16'h7FFF, 16'hFFFF, 1'b1, 0);
    do_op(16'h0000, 16'h0001, 1'b0, 10);

    // reset two cycles into CALC
    check("pre_reset_in_ready", {31'b0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.A = 16'h4321;
    bus.B = 16'h1111;
    bus.sat = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("async_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("async_rst_result_flags", {13'b0, bus.V, bus.Z, bus.N, bus.Result}, 32'd0);
    check("async_rst_state", {30'b0, dbg_state}, {30'b0, IDLE});
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_op(16'h0010, 16'h0001, 1'b0, 0);
    check("post_reset_result", {16'b0, bus.Result}, 32'h000F);

    for (int k = 0; k < 40; k++) begin
      do_op(pick(), pick(), 1'($urandom), $urandom_range(0, 3));
    end

    @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sub_serial_16bit.md
# sub_serial_16bit

Multi-cycle 16-bit subtractor for the ALU datapath. It computes A − B one 4-bit slice per cycle, using a registered borrow chain and a single shared 4-bit slice adder. It covers the SUB and compare paths that the lookahead adder tree does not, and reports N/Z/V flags with optional saturation. Operands enter and results leave through valid/ready handshakes, so the block can sit between the decode stage and the writeback mux.

## Interface
Parameters:
- WIDTH, 16, operand and result width; must be a multiple of SLICE.
- SLICE, 4, bits processed per cycle.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  operands A, B and sat are valid.
- in_ready  output  1  block can accept operands.
- A  input  WIDTH  minuend, two's complement.
- B  input  WIDTH  subtrahend, two's complement.
- sat  input  1  1 = saturate the result on signed overflow.
- out_valid  output  1  Result and flags are valid.
- out_ready  input  1  consumer accepts the result.
- Result  output  WIDTH  A − B, saturated when sat=1 and overflow occurred.
- N  output  1  Result[WIDTH-1].
- Z  output  1  Result == 0.
- V  output  1  signed overflow of the raw difference; reported regardless of sat.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, latch A, ~B and sat into registers.
  - Set carry register to 1 and slice index to 0; go to CALC.
- CALC:
  - in_ready=0.
  - Each cycle, the slice sub-module adds A[idx] + ~B[idx] + carry.
  - The 4-bit sum is written into result slice idx; carry-out goes to the carry register; idx increments.
  - After the slice with idx = WIDTH/SLICE−1, go to DONE.
- V = (A[msb] ≠ B[msb]) && (raw[msb] ≠ A[msb]), using the latched operands.
- Saturation is applied on entry to DONE when sat=1 and V=1:
  - Result = 0x7FFF if A[msb]=0.
  - Result = 0x8000 if A[msb]=1.
- N and Z are computed from the final (post-saturation) Result.
- DONE:
  - out_valid=1; Result and flags are held stable until out_ready.
  - On out_valid && out_ready, go to IDLE.
  - in_ready stays 0 in DONE; no overlap with the next operation.
- Input changes while the block is not in IDLE are ignored (operands are latched).
- Reset, asserted at any time including mid-CALC:
  - FSM goes to IDLE.
  - in_ready=1, out_valid=0.
  - Result=0, N=0, Z=0, V=0.
  - carry=0, idx=0.
  - A partially computed result is discarded.

## Timing
- Accept edge T: in_valid && in_ready sampled high.
- Slice i is written at edge T+1+i, for i = 0..3.
- Saturation and flag registers are written at edge T+4.
- out_valid is high from edge T+4 (latency 4 cycles) until the handshake edge.
- With out_ready held high, minimum issue interval is 6 cycles: accept, 4×CALC, DONE, then back in IDLE.
- in_ready is a pure function of state (high only in IDLE); no combinational path from out_ready to in_ready.
- out_valid, Result and flags come directly from registers.

## Structure
Shared package (alu_pkg):
- State enum {IDLE, CALC, DONE}.
- WIDTH/SLICE constants.
- Saturation constants SAT_POS=16'h7FFF and SAT_NEG=16'h8000.

Sub-module sub_slice_4bit:
- Purely combinational: Sum[3:0], Cout from A, Bn, Cin.
- Instantiated once and multiplexed across slices by idx.

The top level holds the FSM, operand/result registers, and the carry and index registers.

## Test plan
- A=0x0005, B=0x0003, sat=0 → Result=0x0002, N=0, Z=0, V=0; out_valid exactly 4 cycles after accept.
- A=0x1234, B=0x1234 → Result=0x0000, Z=1, N=0, V=0.
- A=0x8000, B=0x0001:
  - sat=1 → Result=0x8000, V=1, N=1.
  - sat=0 → Result=0x7FFF, V=1, N=0.
- A=0x7FFF, B=0xFFFF, sat=1 → Result=0x7FFF, V=1; A=0x0000, B=0x0001 → Result=0xFFFF, N=1, V=0.
- Backpressure:
  - Hold out_ready=0 for 10 cycles → out_valid and Result stay stable and in_ready stays 0.
  - Then raise out_ready → out_valid drops next cycle and in_ready rises.
- Reset and ignored inputs:
  - Assert rst_n=0 two cycles into CALC → all outputs at reset values immediately (asynchronous).
  - After release, a new operation 0x0010−0x0001 → 0x000F.
  - Changing A/B during CALC does not alter the result.
